multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle RISC-V control unit. Replaces the single-cycle decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over one shared instruction/data memory port. Adds a ready/req memory handshake, a wait-state watchdog, JAL, LUI, I-type ALU ops and illegal-opcode reporting. Sits between the instruction register, the ALU and the shared memory in the multi-cycle datapath.

Parameters:
WAIT_LIMIT, 15, max cycles a memory state may wait for MemReady before FAULT; 0 disables the watchdog
CNT_W, 4, width of wait counter; must hold WAIT_LIMIT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
Instr  input  32  instruction register contents
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes the current request this cycle
MemReq  output  1  memory request valid
MemWrite  output  1  store strobe, only with MemReq
AdrSrc  output  1  0=PC, 1=Result
IRWrite  output  1  load instruction register
PCWrite  output  1  load PC from Result
RegWrite  output  1  register file write
ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1, 11=zero
ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4
ImmSrc  output  3  000=I, 001=S, 010=B, 011=U, 100=J
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUctrl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
Illegal  output  1  one-cycle pulse in DECODE for an unsupported instruction
Fault  output  1  sticky watchdog fault
State  output  4  current state, for debug

Behaviour:
- Reset is asynchronous: state=FETCH, wait counter=0, Fault=0. While rst is high, every output is 0 and State reads the FETCH code. Reset asserted mid-transaction drops MemReq in the same cycle.
- Outputs decode combinationally from state, Instr and handshake inputs. Any output not listed for a state is 0.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. When MemReady=1, IRWrite=1 and PCWrite=1 for that cycle, then go to DECODE. Otherwise hold.
- DECODE: ALUSrcA=01, ALUSrcB=01, add. ImmSrc=100 for jal, else 010. Next state by opcode:
  - lw 0000011 or sw 0100011 -> MEMADR
  - R-type 0110011 -> EXECR
  - I-ALU 0010011 -> EXECI
  - branch 1100011 with funct3 000 or 001 -> BRANCH
  - jal 1101111 -> JAL
  - lui 0110111 -> LUI
  - anything else, or an illegal ALU funct -> Illegal=1, go to FETCH (PC already advanced).
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=000 for lw, 001 for sw. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. On MemReady go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00. On MemReady go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00. ALUctrl from funct3/funct7. Then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000. ALUctrl from funct3; never sub. Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = Zero XOR funct3[0] (beq/bne). Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Then ALUWB, which writes OldPC+4.
- LUI: ALUSrcA=11, ALUSrcB=01, ImmSrc=011, add. Then ALUWB.
- ALU decode:
  - funct3 000 -> add; sub only when R-type and Instr[30]=1
  - 010 -> slt; 100 -> xor; 110 -> or; 111 -> and
  - any other funct3 is illegal
  - Instr[30]=1 with R-type funct3 other than 000 is illegal
- Latency with zero wait states: lw 5 cycles; sw, R, I, jal, lui 4; branch 3; illegal 2.
- Wait counter:
  - clears on entry to each memory state (FETCH, MEMREAD, MEMWRITE)
  - increments each cycle MemReady=0 in those states
  - when it reaches WAIT_LIMIT (nonzero) without ready: go to FAULT
- FAULT: all outputs 0, Fault=1. Held until rst.
- A MemReady seen outside a memory state is ignored.

Decomposition:
- control_pkg holds: state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, FAULT), opcode constants, ALUctrl codes, and the ALUSrcA/ALUSrcB/ImmSrc/ResultSrc encodings.
- One sub-module, alu_decoder: combinational; takes opcode, funct3 and Instr[30]; returns ALUctrl plus a legal flag.

Test Plan:
- Reset, then lw x1,4(x0) (0x00402083) with MemReady tied 1 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 with ResultSrc=01 on cycle 5.
- sub x3,x1,x2 (0x402081B3) with ready after 3 idle cycles in FETCH -> IRWrite/PCWrite pulse only on the ready cycle; EXECR ALUctrl=001; 7 cycles total.
- beq (0x00208463) with Zero=1 -> PCWrite=1 in BRANCH. Same with Zero=0 -> PCWrite=0. bne (0x00209463) with Zero=0 -> PCWrite=1.
- jal x1,8 (0x008000EF) -> ImmSrc=100 in DECODE; PCWrite in JAL; RegWrite in ALUWB; lui 0x123450B7 -> ALUSrcA=11, ImmSrc=011.
- Opcode 0x0000007F -> Illegal pulses once in DECODE; next state FETCH.
- MemReady held 0 in MEMREAD for 15 cycles -> Fault=1 and all outputs 0. Assert rst mid-MEMWRITE -> MemReq and MemWrite go 0 immediately; state returns to FETCH.

Source files
------------

// File: rtl/control_pkg.sv
// control_pkg: shared states and encodings for the multi-cycle RISC-V control unit
package control_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, JAL, LUI, FAULT
    } state_t;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    function automatic logic is_mem_state(input state_t s);
        return s == FETCH || s == MEMREAD || s == MEMWRITE;
    endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps funct3/Instr[30] to an ALU operation and flags unsupported encodings
module alu_decoder
    import control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       f7b5,
    output logic [2:0] alu_ctrl,
    output logic       legal
);
    logic rtype;
    assign rtype = opcode == OP_R;
    always_comb begin
        alu_ctrl = funct3 == 3'b000 ? ((rtype && f7b5) ? ALU_SUB : ALU_ADD) :
                   funct3 == 3'b010 ? ALU_SLT :
                   funct3 == 3'b100 ? ALU_XOR :
                   funct3 == 3'b110 ? ALU_OR  : ALU_AND;
        legal = (funct3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111}) &&
                !(rtype && f7b5 && funct3 != 3'b000);
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a multi-cycle RISC-V datapath over one shared memory port
module multicycle_control
    import control_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        MemReq,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ALUctrl,
    output logic        Illegal,
    output logic        Fault,
    output logic [3:0]  State
);
    localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(WAIT_LIMIT);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0] cnt_inc;
    logic [6:0] op;
    logic [2:0] f3, dec_ctrl;
    logic dec_legal, mem_state, timeout, unused_bits;
    assign op          = Instr[6:0];
    assign f3          = Instr[14:12];
    assign unused_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};
    assign mem_state   = is_mem_state(state);
    assign cnt_inc     = {1'b0, cnt} + 1'b1;
    assign timeout     = WAIT_LIMIT != 0 && mem_state && !MemReady && cnt_inc == LIMIT;
    assign State       = state;
    alu_decoder u_alu_dec (
        .opcode   (op),
        .funct3   (f3),
        .f7b5     (Instr[30]),
        .alu_ctrl (dec_ctrl),
        .legal    (dec_legal)
    );
    // counter restarts whenever the state changes, so each memory state gets a fresh budget
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= state_n != state ? '0 : (mem_state && !MemReady) ? cnt_inc[CNT_W-1:0] : cnt;
        end
    end
    always_comb begin
        state_n   = state;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ImmSrc    = IMM_I;
        ResultSrc = RES_ALUOUT;
        ALUctrl   = ALU_ADD;
        Illegal   = 1'b0;
        Fault     = 1'b0;
        case (state)
            FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                state_n   = MemReady ? DECODE : timeout ? FAULT : FETCH;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = op == OP_JAL ? IMM_J : IMM_B;
                case (op)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_R:         state_n = dec_legal ? EXECR : FETCH;
                    OP_I:         state_n = dec_legal ? EXECI : FETCH;
                    OP_BR:        state_n = f3[2:1] == 2'b00 ? BRANCH : FETCH;
                    OP_JAL:       state_n = JAL;
                    OP_LUI:       state_n = LUI;
                    default:      state_n = FETCH;
                endcase
                Illegal = state_n == FETCH;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = op == OP_SW ? IMM_S : IMM_I;
                state_n = op == OP_SW ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                MemReq  = 1'b1;
                AdrSrc  = 1'b1;
                state_n = MemReady ? MEMWB : timeout ? FAULT : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_n   = FETCH;
            end
            MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                state_n  = MemReady ? FETCH : timeout ? FAULT : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUctrl = dec_ctrl;
                state_n = ALUWB;
            end
            EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUctrl = dec_ctrl;
                state_n = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                state_n  = FETCH;
            end
            BRANCH: begin
                ALUSrcA = SRCA_RD1;
                ALUctrl = ALU_SUB;
                PCWrite = Zero ^ f3[0];
                state_n = FETCH;
            end
            JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
                state_n = ALUWB;
            end
            LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
                state_n = ALUWB;
            end
            FAULT: Fault = 1'b1;
            default: state_n = FETCH;
        endcase
        // the FETCH code sits in the state register during reset, so outputs are forced quiet here
        if (rst)
            {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
             ImmSrc, ResultSrc, ALUctrl, Illegal, Fault} = '0;
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and random instruction sequences checked against a phase-level model
module tb_multicycle_control;
    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                   P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9,
                   P_JAL = 10, P_LUI = 11, P_FAULT = 12;
    localparam logic [6:0] LW = 7'h03, SW = 7'h23, ROP = 7'h33, IOP = 7'h13,
                           BR = 7'h63, JALOP = 7'h6F, LUIOP = 7'h37;
    localparam logic [6:0] OPS [7] = '{LW, SW, ROP, IOP, BR, JALOP, LUIOP};
    localparam logic [7:0] F3_OK = 8'b1101_0101;
    localparam logic [2:0] ALU_TBL [8] = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd4, 3'd0, 3'd3, 3'd2};
    localparam logic [31:0] I_LW = 32'h00402083, I_SW = 32'h00112223;

    logic clk = 1'b0, rst, Zero, MemReady;
    logic [31:0] Instr;
    logic MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal, Fault;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc, ALUctrl;
    logic [3:0] State;
    int checks = 0, errors = 0;
    int plan_q[$];

    multicycle_control dut (
        .clk(clk), .rst(rst), .Instr(Instr), .Zero(Zero), .MemReady(MemReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .ALUctrl(ALUctrl), .Illegal(Illegal),
        .Fault(Fault), .State(State)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ev(input logic [3:0] st, input logic [5:0] s, input logic [1:0] a,
                                       input logic [1:0] b, input logic [2:0] imm, input logic [1:0] res,
                                       input logic [2:0] alu, input logic ill, input logic flt);
        return {st, s, a, b, imm, res, alu, ill, flt};
    endfunction

    function automatic logic legal(input logic [31:0] ins);
        logic [2:0] f3 = ins[14:12];
        case (ins[6:0])
            LW, SW, JALOP, LUIOP: return 1'b1;
            BR:      return f3 < 3'd2;
            ROP:     return F3_OK[f3] && (!ins[30] || f3 == 3'd0);
            IOP:     return F3_OK[f3];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [31:0] ins);
        return (ins[14:12] == 3'd0 && ins[6:0] == ROP && ins[30]) ? 3'd1 : ALU_TBL[ins[14:12]];
    endfunction

    function automatic void make_plan(input logic [31:0] ins);
        plan_q.delete();
        plan_q.push_back(P_FETCH);
        plan_q.push_back(P_DECODE);
        if (legal(ins))
            case (ins[6:0])
                LW: begin plan_q.push_back(P_MEMADR); plan_q.push_back(P_MEMREAD); plan_q.push_back(P_MEMWB); end
                SW: begin plan_q.push_back(P_MEMADR); plan_q.push_back(P_MEMWRITE); end
                ROP: begin plan_q.push_back(P_EXECR); plan_q.push_back(P_ALUWB); end
                IOP: begin plan_q.push_back(P_EXECI); plan_q.push_back(P_ALUWB); end
                BR: plan_q.push_back(P_BRANCH);
                JALOP: begin plan_q.push_back(P_JAL); plan_q.push_back(P_ALUWB); end
                default: begin plan_q.push_back(P_LUI); plan_q.push_back(P_ALUWB); end
            endcase
    endfunction

    function automatic logic [23:0] exp_phase(input int ph, input logic [31:0] ins, input logic rdy, input logic z);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        case (ph)
            P_FETCH:    return ev(4'd0, {3'b100, rdy, rdy, 1'b0}, 2'b00, 2'b10, 3'b000, 2'b10, 3'd0, 1'b0, 1'b0);
            P_DECODE:   return ev(4'd1, 6'b000000, 2'b01, 2'b01, op == JALOP ? 3'b100 : 3'b010, 2'b00, 3'd0, !legal(ins), 1'b0);
            P_MEMADR:   return ev(4'd2, 6'b000000, 2'b10, 2'b01, op == SW ? 3'b001 : 3'b000, 2'b00, 3'd0, 1'b0, 1'b0);
            P_MEMREAD:  return ev(4'd3, 6'b101000, 2'b00, 2'b00, 3'b000, 2'b00, 3'd0, 1'b0, 1'b0);
            P_MEMWB:    return ev(4'd4, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b01, 3'd0, 1'b0, 1'b0);
            P_MEMWRITE: return ev(4'd5, 6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 3'd0, 1'b0, 1'b0);
            P_EXECR:    return ev(4'd6, 6'b000000, 2'b10, 2'b00, 3'b000, 2'b00, alu_of(ins), 1'b0, 1'b0);
            P_EXECI:    return ev(4'd7, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, alu_of(ins), 1'b0, 1'b0);
            P_ALUWB:    return ev(4'd8, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 3'd0, 1'b0, 1'b0);
            P_BRANCH:   return ev(4'd9, {4'b0000, z ^ f3[0], 1'b0}, 2'b10, 2'b00, 3'b000, 2'b00, 3'd1, 1'b0, 1'b0);
            P_JAL:      return ev(4'd10, 6'b000010, 2'b01, 2'b10, 3'b000, 2'b00, 3'd0, 1'b0, 1'b0);
            P_LUI:      return ev(4'd11, 6'b000000, 2'b11, 2'b01, 3'b011, 2'b00, 3'd0, 1'b0, 1'b0);
            default:    return ev(4'd12, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'd0, 1'b0, 1'b1);
        endcase
    endfunction

    task automatic chk(input logic [23:0] e, input string tag);
        logic [23:0] o;
        o = {State, MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
             ImmSrc, ResultSrc, ALUctrl, Illegal, Fault};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic cyc(input logic rdy, input logic z, input logic [31:0] ins, input int ph, input string tag);
        MemReady = rdy;
        Zero     = z;
        Instr    = ins;
        #1;
        chk(exp_phase(ph, ins, rdy, z), tag);
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] ins, input int fw, input int mw, input logic z, input string tag);
        make_plan(ins);
        foreach (plan_q[k]) begin
            int ph;
            ph = plan_q[k];
            if (ph == P_FETCH || ph == P_MEMREAD || ph == P_MEMWRITE) begin
                for (int i = 0; i < (ph == P_FETCH ? fw : mw); i++) cyc(1'b0, z, ins, ph, tag);
                cyc(1'b1, z, ins, ph, tag);
            end else
                cyc(1'($urandom_range(0, 1)), z, ins, ph, tag);
        end
    endtask

    initial begin
        rst = 1'b1; Instr = '0; Zero = 1'b0; MemReady = 1'b0;
        #1 chk(24'h0, "reset_hold");
        @(negedge clk);
        MemReady = 1'b1;
        #1 chk(24'h0, "reset_ready");
        @(negedge clk);
        rst = 1'b0; MemReady = 1'b0;
        run(I_LW, 0, 0, 1'b0, "lw");
        run(32'h402081B3, 3, 0, 1'b0, "sub");
        run(32'h00208463, 0, 0, 1'b1, "beq_taken");
        run(32'h00208463, 0, 0, 1'b0, "beq_not_taken");
        run(32'h00209463, 0, 0, 1'b0, "bne_taken");
        run(32'h008000EF, 0, 0, 1'b0, "jal");
        run(32'h123450B7, 0, 0, 1'b0, "lui");
        run(32'h0000007F, 0, 0, 1'b0, "illegal_op");
        run(32'h00209133, 0, 0, 1'b0, "sll_illegal");
        run(32'h4020C1B3, 0, 0, 1'b0, "f7_illegal");
        run(I_LW, 14, 14, 1'b0, "lw_wait14");
        run(I_SW, 2, 3, 1'b0, "sw");
        for (int n = 0; n < 60; n++) begin
            logic [31:0] ins;
            int k;
            ins = $urandom();
            k = $urandom_range(0, 7);
            if (k < 7) ins[6:0] = OPS[k];
            run(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
        end
        cyc(1'b1, 1'b0, I_LW, P_FETCH, "wd_fetch");
        cyc(1'b0, 1'b0, I_LW, P_DECODE, "wd_decode");
        cyc(1'b0, 1'b0, I_LW, P_MEMADR, "wd_memadr");
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, I_LW, P_MEMREAD, "wd_wait");
        for (int i = 0; i < 3; i++) cyc(1'($urandom_range(0, 1)), 1'b0, I_LW, P_FAULT, "wd_fault");
        rst = 1'b1;
        #1 chk(24'h0, "wd_reset");
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0, I_SW, P_FETCH, "mw_fetch");
        cyc(1'b0, 1'b0, I_SW, P_DECODE, "mw_decode");
        cyc(1'b0, 1'b0, I_SW, P_MEMADR, "mw_memadr");
        MemReady = 1'b0;
        #1 chk(exp_phase(P_MEMWRITE, I_SW, 1'b0, 1'b0), "mw_pending");
        rst = 1'b1;
        #1 chk(24'h0, "mw_reset");
        @(negedge clk);
        rst = 1'b0;
        run(I_LW, 1, 1, 1'b0, "after_reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
